// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmitter through a start/busy handshake
module uart_tx_queue #(
  parameter int DEPTH = 16,
  parameter int START_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   tx_busy,
  output logic [7:0]             tx_data,
  output logic                   tx_start
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [7:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [TW-1:0] r_to;
  logic r_full, r_empty, r_overflow, r_tx_start;
  logic [7:0] r_tx_data;
  logic w_pop, w_wr, w_timeout;
  // a pop frees a slot in the same cycle, so a full FIFO can still accept
  assign w_pop = r_state == IDLE && !r_empty && !tx_busy;
  assign w_wr = wr_en && (!r_full || w_pop);
  assign w_timeout = r_to == TW'(START_TIMEOUT - 1);
  assign w_count_nxt = (w_wr && !w_pop) ? r_count + 1'b1 : (!w_wr && w_pop) ? r_count - 1'b1 : r_count;
  assign full = r_full;
  assign empty = r_empty;
  assign count = r_count;
  assign overflow = r_overflow;
  assign tx_data = r_tx_data;
  assign tx_start = r_tx_start;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      w_state_nxt = w_pop ? WAIT_BUSY : IDLE;
      WAIT_BUSY: w_state_nxt = tx_busy ? WAIT_DONE : w_timeout ? IDLE : WAIT_BUSY;
      WAIT_DONE: w_state_nxt = tx_busy ? WAIT_DONE : IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end
  // pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_to       <= '0;
    end else begin
      r_wr_ptr   <= w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr   <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count    <= w_count_nxt;
      r_full     <= w_count_nxt == CW'(DEPTH);
      r_empty    <= w_count_nxt == '0;
      r_overflow <= wr_en && !w_wr;
      r_tx_start <= w_pop;
      r_tx_data  <= w_pop ? r_mem[r_rd_ptr] : r_tx_data;
      r_to       <= (r_state == WAIT_BUSY && !w_timeout) ? r_to + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: directed checks of the UART transmit queue and its handshake FSM
module tb_uart_tx_queue;
  logic clk = 0, rst = 1, wr_en = 0, busy_drv = 0, model_en = 0, prev_start = 0;
  logic [7:0] wr_data = 0, tx_data;
  logic full, empty, overflow, tx_start, tx_busy;
  logic [4:0] count;
  int checks = 0, errors = 0, cyc = 0, ovf_cnt = 0, dbl = 0, m_cnt = 0;
  byte unsigned q[$];
  int t[$];
  always #5 clk = ~clk;
  // transmitter model: busy rises one cycle after tx_start and lasts ten cycles
  assign tx_busy = model_en ? (m_cnt != 0) : busy_drv;
  always @(posedge clk) m_cnt <= !model_en ? 0 : tx_start ? 10 : (m_cnt != 0) ? m_cnt - 1 : 0;
  always @(negedge clk) begin
    cyc++;
    if (tx_start) begin
      q.push_back(tx_data);
      t.push_back(cyc);
    end
    if (tx_start && prev_start) dbl++;
    if (overflow) ovf_cnt++;
    prev_start = tx_start;
  end
  uart_tx_queue #(.DEPTH(16), .START_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [7:0] b);
    wr_en = 1;
    wr_data = b;
    @(negedge clk);
    wr_en = 0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", tx_data, 0);
    rst = 0;
    wr(8'h41);
    chk("w1_count", count, 1);
    chk("w1_empty", empty, 0);
    chk("w1_start", tx_start, 0);
    @(negedge clk);
    chk("s1_start", tx_start, 1);
    chk("s1_data", tx_data, 8'h41);
    chk("s1_empty", empty, 1);
    @(negedge clk);
    chk("s1_pulse", tx_start, 0);
    wr(8'h42);
    repeat (2) begin
      @(negedge clk);
      chk("to_wait", tx_start, 0);
    end
    @(negedge clk);
    chk("to_start", tx_start, 1);
    chk("to_data", tx_data, 8'h42);
    repeat (6) @(negedge clk);
    q.delete();
    t.delete();
    model_en = 1;
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    for (int i = 0; i < 100 && q.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    chk("hs_n", q.size(), 3);
    chk("hs_b0", q[0], 8'h01);
    chk("hs_b1", q[1], 8'h02);
    chk("hs_b2", q[2], 8'h03);
    chk("hs_gap1", t[1] - t[0], 13);
    chk("hs_gap2", t[2] - t[1], 13);
    repeat (15) @(negedge clk);
    model_en = 0;
    busy_drv = 1;
    q.delete();
    t.delete();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1;
      wr_data = 8'(8'h10 + i);
      @(negedge clk);
    end
    wr_en = 0;
    chk("of_full", full, 1);
    chk("of_count", count, 16);
    chk("of_ovf", overflow, 1);
    @(negedge clk);
    chk("of_pulse", overflow, 0);
    wr_en = 1;
    wr_data = 8'h55;
    busy_drv = 0;
    model_en = 1;
    @(negedge clk);
    wr_en = 0;
    chk("pw_count", count, 16);
    chk("pw_full", full, 1);
    chk("pw_ovf", overflow, 0);
    chk("pw_start", tx_start, 1);
    chk("pw_data", tx_data, 8'h10);
    #1;
    chk("of_cnt", ovf_cnt, 1);
    for (int i = 0; i < 300 && q.size() < 12; i++) begin
      @(negedge clk);
      #1;
    end
    chk("dr_n", q.size(), 12);
    for (int i = 0; i < 12; i++) chk("dr_order", q[i], 8'h10 + i);
    repeat (3) @(negedge clk);
    chk("mid_count", count, 5);
    #2 rst = 1;
    #1;
    chk("ar_empty", empty, 1);
    chk("ar_full", full, 0);
    chk("ar_count", count, 0);
    chk("ar_start", tx_start, 0);
    chk("ar_data", tx_data, 0);
    chk("ar_ovf", overflow, 0);
    model_en = 0;
    busy_drv = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (30) @(negedge clk);
    #1;
    chk("post_n", q.size(), 12);
    chk("post_empty", empty, 1);
    chk("no_double", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
